// File: rtl/wdt_pkg.sv
// Watchdog shared types and default widths. WARN exists only when WDT_WARN_IRQ_EN is defined.
// Latency: n/a (types only); backpressure: none.
package wdt_pkg;

  localparam int CNT_WIDTH = 32;
  localparam int PSC_WIDTH = 16;
  localparam int RST_PULSE = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    RESET = 2'd2
`ifdef WDT_WARN_IRQ_EN
    ,
    WARN  = 2'd3
`endif
  } wdt_state_e;

endpackage

// File: rtl/wdt_presc.sv
// Tick prescaler: one tick_o every div_i+1 enabled cycles; clr_i restarts the phase.
// Latency: tick_o is combinational from the phase register; backpressure: none.
module wdt_presc #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] div_i,
  output logic         tick_o
);

  logic [W-1:0] phase;

  assign tick_o = en_i && (phase == div_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      phase <= '0;
    end else if (en_i) begin
      phase <= tick_o ? '0 : phase + W'(1);
    end
  end

endmodule

// File: rtl/wdt_core.sv
// Watchdog timer: prescaled down-counter, reset-request pulse, sticky flag; WARN/irq under WDT_WARN_IRQ_EN.
// Latency: outputs registered, reset request lags RESET entry by one cycle; backpressure: none.
module wdt_core #(
  parameter int CNT_WIDTH = wdt_pkg::CNT_WIDTH,
  parameter int PSC_WIDTH = wdt_pkg::PSC_WIDTH,
  parameter int RST_PULSE = wdt_pkg::RST_PULSE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [PSC_WIDTH-1:0] psc_i,
  input  logic [CNT_WIDTH-1:0] tmo_i,
  input  logic [CNT_WIDTH-1:0] warn_i,
  input  logic                 feed_i,
  input  logic                 flag_clr_i,
  output logic                 wdt_rst_n_o,
  output logic                 irq_o,
  output logic                 rst_flag_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);
  import wdt_pkg::*;

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  wdt_state_e           state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [PW-1:0]        pulse, pulse_n;
  logic                 tick, presc_clr, active;

`ifdef WDT_WARN_IRQ_EN
  logic irq_q;
  assign active = (state == COUNT) || (state == WARN);
  assign irq_o  = irq_q;
`else
  logic unused_warn;
  assign active      = (state == COUNT);
  assign irq_o       = 1'b0;
  assign unused_warn = ^warn_i;
`endif

  assign cnt_o = cnt;

  wdt_presc #(.W(PSC_WIDTH)) u_presc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (presc_clr),
    .en_i   (active),
    .div_i  (psc_i),
    .tick_o (tick)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pulse_n   = pulse;
    presc_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (en_i) begin
          cnt_n     = tmo_i;
          presc_clr = 1'b1;
          state_n   = COUNT;
        end
      end
      RESET: begin
        if (pulse == PW'(RST_PULSE - 1)) begin
          pulse_n = '0;
          if (en_i) begin
            cnt_n     = tmo_i;
            presc_clr = 1'b1;
            state_n   = COUNT;
          end else begin
            state_n = IDLE;
          end
        end else begin
          pulse_n = pulse + PW'(1);
        end
      end
      default: begin
        // Disable beats feed, feed beats an expiring tick.
        if (!en_i) begin
          state_n = IDLE;
        end else if (feed_i) begin
          cnt_n     = tmo_i;
          presc_clr = 1'b1;
          state_n   = COUNT;
        end else if (tick) begin
          if (cnt == '0) begin
            state_n = RESET;
            pulse_n = '0;
          end else begin
            cnt_n = cnt - CNT_WIDTH'(1);
`ifdef WDT_WARN_IRQ_EN
            if ((state == COUNT) && (cnt_n <= warn_i)) state_n = WARN;
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      pulse       <= '0;
      wdt_rst_n_o <= 1'b1;
      rst_flag_o  <= 1'b0;
`ifdef WDT_WARN_IRQ_EN
      irq_q       <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pulse       <= pulse_n;
      wdt_rst_n_o <= (state != RESET);
`ifdef WDT_WARN_IRQ_EN
      irq_q       <= (state_n == WARN);
`endif
      if ((state_n == RESET) && (state != RESET)) begin
        rst_flag_o <= 1'b1;
      end else if (flag_clr_i) begin
        rst_flag_o <= 1'b0;
      end
    end
  end

endmodule
